// File: rtl/ring_game_pkg.sv
// Shared types and widths for the ring game sequencer.
// Counter widths are sized for the default period and hold time.
package ring_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_JUDGE = 3'd2,
        ST_SHOW  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int PERIOD_L0_DEF = 1000;
    localparam int HOLD_CYC_DEF  = 500;

    // Any PERIOD_L0 up to 2**PRE_W and HOLD_CYC up to 2**HOLD_W fit these counters.
    localparam int PRE_W  = $clog2(PERIOD_L0_DEF);
    localparam int HOLD_W = $clog2(HOLD_CYC_DEF);

    function automatic logic [PRE_W-1:0] step_period(input int p0, input int dec,
                                                     input logic [2:0] lvl);
        return PRE_W'(p0 - dec * int'(lvl));
    endfunction

endpackage

// File: rtl/ring_tick_gen.sv
// Prescaler for the ring step: counts 0..period-1 while enabled and flags the last count.
// tick is combinational here; the caller registers it into step_en.
module ring_tick_gen
    import ring_game_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] period,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q, cnt_d;
    logic             at_end;

    always_comb begin
        // >= rather than == so a count left above a shortened period still wraps.
        at_end = (cnt_q >= period - PRE_W'(1));
        tick   = en && at_end;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ring_game_ctrl.sv
// Ring game sequencer: paces the ring with step_en, judges stop presses, keeps score/level/misses.
//   state | meaning
//   IDLE  | waiting for first start after reset
//   RUN   | ring stepping at the level's period, waiting for stop
//   JUDGE | one cycle, ring frozen, ring_pos sampled
//   SHOW  | result held for HOLD_CYC cycles
//   OVER  | MAX_MISS reached, waiting for start
module ring_game_ctrl
    import ring_game_pkg::*;
#(
    parameter int PERIOD_L0  = 1000,
    parameter int PERIOD_DEC = 100,
    parameter int NUM_LEVELS = 8,
    parameter int TARGET_BIT = 12,
    parameter int HOLD_CYC   = 500,
    parameter int MAX_MISS   = 3,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start,
    input  logic               btn_stop,
    input  logic [14:0]        ring_pos,
    output logic               step_en,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         level,
    output logic [1:0]         misses,
    output logic               game_over
);

    localparam logic [2:0]        LEVEL_MAX = 3'(NUM_LEVELS - 1);
    localparam logic [1:0]        MISS_END  = 2'(MAX_MISS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [2:0]          level_q, level_d;
    logic [1:0]          misses_q, misses_d;
    logic                step_en_q, step_en_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic                game_over_q, game_over_d;

    logic                tick;
    logic                pre_en;
    logic                pre_clr;
    logic [PRE_W-1:0]    period;
    logic                unused_ring;

    assign unused_ring = ^ring_pos;

    assign period = step_period(PERIOD_L0, PERIOD_DEC, level_q);
    assign pre_en = (state_q == ST_RUN);

    ring_tick_gen u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pre_en),
        .clr    (pre_clr),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        score_d   = score_q;
        level_d   = level_q;
        misses_d  = misses_q;
        step_en_d = 1'b0;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        pre_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_start) begin
                    state_d = ST_RUN;
                    pre_clr = 1'b1;
                end
            end
            ST_RUN: begin
                // Stop beats a coincident wrap so the ring stays frozen for JUDGE.
                if (btn_stop) begin
                    state_d = ST_JUDGE;
                end else begin
                    step_en_d = tick;
                end
            end
            ST_JUDGE: begin
                if (ring_pos[TARGET_BIT]) begin
                    hit_d = 1'b1;
                    if (score_q != '1)       score_d = score_q + 1'b1;
                    if (level_q < LEVEL_MAX) level_d = level_q + 1'b1;
                end else begin
                    miss_d = 1'b1;
                    if (misses_q != '1) misses_d = misses_q + 1'b1;
                end
                hold_d  = '0;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (hold_q >= HOLD_LAST) begin
                    if (misses_q >= MISS_END) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_RUN;
                        pre_clr = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_OVER: begin
                if (btn_start) begin
                    score_d  = '0;
                    level_d  = '0;
                    misses_d = '0;
                    state_d  = ST_RUN;
                    pre_clr  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            score_q     <= '0;
            level_q     <= '0;
            misses_q    <= '0;
            step_en_q   <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            score_q     <= score_d;
            level_q     <= level_d;
            misses_q    <= misses_d;
            step_en_q   <= step_en_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            game_over_q <= game_over_d;
        end
    end

    assign step_en   = step_en_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign level     = level_q;
    assign misses    = misses_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_ring_game_ctrl.sv
// Scoreboard bench for ring_game_ctrl: stimulus queues expected pulses, a monitor checks them.
// The bench models the ring counter itself, advancing it on each step_en.
module tb_ring_game_ctrl;

    localparam int P0  = 20;
    localparam int DEC = 2;
    localparam int HLD = 5;
    localparam int SW  = 8;

    localparam int K_STEP = 4;
    localparam int K_HIT  = 2;
    localparam int K_MISS = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_start = 1'b0;
    logic          btn_stop = 1'b0;
    logic [14:0]   ring_pos;
    logic          step_en, hit, miss, game_over;
    logic [SW-1:0] score;
    logic [2:0]    level;
    logic [1:0]    misses;

    typedef struct {
        int kind;
        int at;
        int score;
        int level;
        int misses;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int hw_idx = 0;

    int m_score = 0, m_level = 0, m_misses = 0, m_idx = 0, r0 = 0;

    ring_game_ctrl #(
        .PERIOD_L0  (P0),
        .PERIOD_DEC (DEC),
        .NUM_LEVELS (8),
        .TARGET_BIT (12),
        .HOLD_CYC   (HLD),
        .MAX_MISS   (3),
        .SCORE_W    (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .ring_pos  (ring_pos),
        .step_en   (step_en),
        .hit       (hit),
        .miss      (miss),
        .score     (score),
        .level     (level),
        .misses    (misses),
        .game_over (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (step_en) hw_idx <= (hw_idx + 1) % 5;
    assign ring_pos = 15'(32'd1 << (3 * hw_idx));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (step_en || hit || miss)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: step_en=%0d hit=%0d miss=%0d at cycle %0d, none expected",
                         step_en, hit, miss, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind",   int'({step_en, hit, miss}), mon_e.kind);
                check("pulse_cycle",  cyc, mon_e.at);
                check("pulse_score",  int'(score), mon_e.score);
                check("pulse_level",  int'(level), mon_e.level);
                check("pulse_misses", int'(misses), mon_e.misses);
            end
        end
    end

    task automatic push(input int kind, input int at);
        exp_t e;
        e.kind = kind; e.at = at;
        e.score = m_score; e.level = m_level; e.misses = m_misses;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_step_en"},   int'(step_en), 0);
        check({tag, "_hit"},       int'(hit), 0);
        check({tag, "_miss"},      int'(miss), 0);
        check({tag, "_score"},     int'(score), 0);
        check({tag, "_level"},     int'(level), 0);
        check({tag, "_misses"},    int'(misses), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
    endtask

    task automatic start_game(input logic with_stop);
        btn_start = 1'b1;
        btn_stop  = with_stop;
        r0 = cyc + 1;
        m_score = 0; m_level = 0; m_misses = 0;
        @(negedge clk);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
    endtask

    // Stop 'wt' cycles into RUN; steps landing at or before the stop cycle are expected.
    task automatic play_round(input int wt);
        int p, s, n;
        p = P0 - DEC * m_level;
        s = r0 + wt;
        n = wt / p;
        for (int k = 1; k <= n; k++) push(K_STEP, r0 + k * p);
        m_idx = (m_idx + n) % 5;
        if (m_idx == 4) begin
            if (m_score < 255) m_score++;
            if (m_level < 7)   m_level++;
            push(K_HIT, s + 2);
        end else begin
            if (m_misses < 3) m_misses++;
            push(K_MISS, s + 2);
        end
        wait_until(s);
        btn_stop = 1'b1;
        @(negedge clk);
        btn_stop = 1'b0;
        r0 = s + 2 + HLD;
    endtask

    task automatic play_hit();
        play_round(((4 - m_idx + 5) % 5) * (P0 - DEC * m_level) + 3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_game(1'b0);
        play_round(4 * 20 + 3);          // four steps at period 20, then hit
        play_round(2 * 18 + 5);          // period now 18, stop on bit 3 -> miss
        play_round(4 * 18 - 1);          // stop coincides with wrap, hit
        play_round(16 + 3);              // miss
        play_round(3);                   // third miss -> OVER

        wait_until(r0 + 10);
        check("over_game_over", int'(game_over), 1);
        check("over_misses", int'(misses), 3);
        btn_stop = 1'b1;
        @(negedge clk);
        btn_stop = 1'b0;
        repeat (30) @(negedge clk);
        check("over_still", int'(game_over), 1);

        start_game(1'b1);                // start beats a simultaneous stop in OVER
        check("restart_game_over", int'(game_over), 0);
        check("restart_score", int'(score), 0);
        check("restart_level", int'(level), 0);
        check("restart_misses", int'(misses), 0);

        for (int i = 0; i < 5; i++) play_hit();
        wait_until(r0 - 3);              // inside SHOW after the fifth hit
        check("show_score", int'(score), 5);
        rst_n = 1'b0;
        #1;
        check_all_zero("midshow_rst");
        @(negedge clk);
        rst_n = 1'b1;
        m_score = 0; m_level = 0; m_misses = 0;

        @(negedge clk);
        btn_stop = 1'b1;
        @(negedge clk);
        btn_stop = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_score", int'(score), 0);
        check("idle_game_over", int'(game_over), 0);

        start_game(1'b0);
        play_round(2 * 20 + 7);
        wait_until(r0 + 2);

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
